icache_tag_req_sched: RTL

Schedules the single icache tag-lookup port among three requesters: upstream fetch, downstream snoop and prefetch. Base priority is fixed, with age-based anti-starvation promotion layered on top. The winner is registered into a one-entry output stage, so the tag pipeline sees a clean registered valid/payload. Prefetch traffic can also be gated off by a throttle input. The block sits between the request sources and the tag RAM / MSHR lookup stage.

---
 rtl/icache_tag_req_sched.sv | 138 +++++++++++++
 1 files changed

// File: rtl/icache_tag_req_sched.sv
// icache_tag_req_sched: arbitrates the single icache tag-lookup port between
// fetch, snoop and prefetch, with fixed priority plus age-based promotion,
// and registers the winner into a one-entry output stage.

package icache_tag_req_sched_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  ctx;
    } pc_req_t;
endpackage

module icache_tag_req_sched
    import icache_tag_req_sched_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       upstream_rxreq_vld,
    output logic       upstream_rxreq_rdy,
    input  pc_req_t    upstream_rxreq_pld,
    input  logic       downstream_rxsnp_vld,
    output logic       downstream_rxsnp_rdy,
    input  pc_req_t    downstream_rxsnp_pld,
    input  logic       prefetch_req_vld,
    output logic       prefetch_req_rdy,
    input  pc_req_t    prefetch_req_pld,
    input  logic       prefetch_en,
    output logic       tag_req_vld,
    input  logic       tagram_req_rdy,
    input  logic       mshr_tag_req_rdy,
    output pc_req_t    tag_req_pld,
    output logic [1:0] tag_req_src
);

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    logic             out_rdy;
    logic             load_en;
    logic [2:0]       elig;
    logic [2:0]       urgent;
    logic [2:0]       grant;
    logic [AGE_W-1:0] age [3];
    pc_req_t          pld_mux;
    logic [1:0]       src_mux;

    // Saturating increment of an age counter at the starvation threshold.
    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (a == AGE_MAX) ? a : a + 1'b1;
    endfunction

    assign out_rdy = tagram_req_rdy & mshr_tag_req_rdy;
    assign load_en = !tag_req_vld | out_rdy;

    assign elig[0] = upstream_rxreq_vld;
    assign elig[1] = downstream_rxsnp_vld;
    assign elig[2] = prefetch_req_vld & prefetch_en;

    // A waiting source that has lost STARVE_LIMIT rounds jumps the queue.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            urgent[i] = elig[i] & (age[i] == AGE_MAX);
        end
    end

    // One-hot grant: lowest-index urgent source first, else fixed priority.
    always_comb begin
        grant = 3'b000;
        if (load_en) begin
            if (|urgent) begin
                if (urgent[0])      grant = 3'b001;
                else if (urgent[1]) grant = 3'b010;
                else                grant = 3'b100;
            end else begin
                if (elig[0])        grant = 3'b001;
                else if (elig[1])   grant = 3'b010;
                else if (elig[2])   grant = 3'b100;
            end
        end
    end

    // Payload and source index of the granted requester.
    always_comb begin
        pld_mux = upstream_rxreq_pld;
        src_mux = 2'd0;
        if (grant[1]) begin
            pld_mux = downstream_rxsnp_pld;
            src_mux = 2'd1;
        end else if (grant[2]) begin
            pld_mux = prefetch_req_pld;
            src_mux = 2'd2;
        end
    end

    assign upstream_rxreq_rdy   = load_en & grant[0] & rst_n;
    assign downstream_rxsnp_rdy = load_en & grant[1] & rst_n;
    assign prefetch_req_rdy     = load_en & grant[2] & rst_n;

    // Output stage: load the winner whenever the entry is empty or draining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_req_vld <= 1'b0;
            tag_req_src <= 2'd0;
            tag_req_pld <= '0;
        end else if (load_en) begin
            tag_req_vld <= |grant;
            if (|grant) begin
                tag_req_pld <= pld_mux;
                tag_req_src <= src_mux;
            end
        end
    end

    // Age counters: advance only on arbitration cycles; prefetch age pinned
    // to zero while throttled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                age[i] <= '0;
            end
        end else begin
            if (load_en) begin
                for (int i = 0; i < 3; i++) begin
                    if (grant[i] || !elig[i]) begin
                        age[i] <= '0;
                    end else if (|grant) begin
                        age[i] <= age_inc(age[i]);
                    end
                end
            end
            if (!prefetch_en) begin
                age[2] <= '0;
            end
        end
    end

endmodule
